ddr3_rw_arbiter: RTL and testbench
==================================

// Module: ddr3_rw_arbiter
// PURPOSE
//  Schedules burst writes and reads onto the single DDR3 user port (per-beat command interface of the MIG wrapper).
//  Treats a DDR3 region as a ring buffer: drains an upstream FWFT write FIFO into DDR3, reads back into a downstream FIFO.
//  Round-robin arbitration between write and read bursts; generates all DDR3 beat addresses internally.
// PARAMETERS
//  ADDR_W     29    DDR3 app address width (= MEM_ADDR_SIZE)
//  BURST_LEN  32    beats per granted burst (power of 2, >=1)
//  ADDR_STEP  8     app address increment per 512-bit beat
//  BASE_ADDR  0     ring base address (ADDR_W bits)
//  BUF_BEATS  4096  ring size in beats (power of 2, multiple of BURST_LEN)
// PORTS
//  ui_clk               in   1       clock
//  ui_clk_sync_rst      in   1       reset, asynchronous, active-high
//  init_calib_complete  in   1       DDR3 calibration done
//  wr_fifo_count        in   16      beats available in upstream write FIFO
//  wr_fifo_dout         in   512     upstream FIFO head data (FWFT)
//  wr_fifo_rd_en        out  1       pop upstream FIFO
//  rd_space             in   16      free beats in downstream read FIFO
//  ddr_wr_valid         out  1       write beat valid
//  ddr_wr_addr          out  ADDR_W  write beat address
//  ddr_wr_data          out  512     write beat data
//  ddr_wr_ready         in   1       DDR3 port accepts write beat
//  ddr_rd_valid         out  1       read command valid
//  ddr_rd_addr          out  ADDR_W  read command address
//  ddr_rd_ready         in   1       DDR3 port accepts read command
//  ddr_rd_data_valid    in   1       one read beat returned
//  occupancy            out  log2(BUF_BEATS)+1  beats written not yet read
//  busy                 out  1       burst in progress
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; wr_ptr, rd_ptr, occupancy, outstanding, beat_cnt = 0; last_grant = READ.
//  FSM: IDLE -> ARB when init_calib_complete=1 (sampled only in IDLE).
//   ARB: wr_elig = wr_fifo_count>=BURST_LEN && (BUF_BEATS-occupancy)>=BURST_LEN.
//        rd_elig = occupancy>=BURST_LEN && rd_space>=BURST_LEN+outstanding.
//        both eligible -> grant opposite of last_grant; one -> grant it; none -> stay ARB.
//        grant registers last_grant, clears beat_cnt; next state WR_BURST or RD_BURST (1 cycle in ARB min).
//   WR_BURST: ddr_wr_valid=1; beat on ddr_wr_valid&ddr_wr_ready; ddr_wr_data=wr_fifo_dout (comb);
//        wr_fifo_rd_en = beat (same cycle); after BURST_LEN-th beat -> ARB.
//   RD_BURST: ddr_rd_valid=1; beat on ddr_rd_valid&ddr_rd_ready; after BURST_LEN-th beat -> ARB.
//  busy=1 in WR_BURST/RD_BURST. Valid held until accepted; address/data stable while ready=0.
//  Addresses: ddr_x_addr = BASE_ADDR + ptr*ADDR_STEP (ADDR_W bits, truncating); ptr +1 per beat,
//   wraps BUF_BEATS-1 -> 0 (ptr width log2(BUF_BEATS)).
//  occupancy: +BURST_LEN at end of write burst, -BURST_LEN at end of read burst (never both same cycle).
//  outstanding: +1 per accepted read command, -1 per ddr_rd_data_valid; both same cycle -> unchanged.
//  rd_data_valid with outstanding=0 is ignored (counter saturates at 0).
//  Eligibility checked once per burst at grant; burst never aborted mid-way except by reset.
//  Reset mid-burst: immediate return to reset values; ring contents considered lost.
// TESTING
//  T1 reset, calib=0 for 50 cyc, wr_fifo_count=64 -> stays IDLE, no valid; calib=1 -> WR_BURST 2 cycles later.
//  T2 wr_fifo_count=32, ready=1 -> 32 wr beats addr 0,8,..,248, 32 rd_en pulses, occupancy=32, busy low after.
//  T3 occupancy=64, wr_fifo_count=64, rd_space=512 -> grants alternate RD,WR,RD (last_grant=WR initially).
//  T4 BUF_BEATS=64: write 64 beats, read 32, write 32 -> last write addrs wrap to 0..248; full ring blocks writes.
//  T5 ddr_wr_ready toggled randomly -> addr/data stable while not ready, exactly BURST_LEN pops, no FIFO underflow.
//  T6 rd_space=40, read burst issued, no data returned -> second read not granted until outstanding<=8.

Source files
------------

// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: round-robin scheduler of write/read bursts onto one DDR3 user port, using a DDR3 region as a ring buffer
module ddr3_rw_arbiter #(
  parameter int ADDR_W = 29,
  parameter int BURST_LEN = 32,
  parameter int ADDR_STEP = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int BUF_BEATS = 4096
) (
  input  logic ui_clk,
  input  logic ui_clk_sync_rst,
  input  logic init_calib_complete,
  input  logic [15:0] wr_fifo_count,
  input  logic [511:0] wr_fifo_dout,
  output logic wr_fifo_rd_en,
  input  logic [15:0] rd_space,
  output logic ddr_wr_valid,
  output logic [ADDR_W-1:0] ddr_wr_addr,
  output logic [511:0] ddr_wr_data,
  input  logic ddr_wr_ready,
  output logic ddr_rd_valid,
  output logic [ADDR_W-1:0] ddr_rd_addr,
  input  logic ddr_rd_ready,
  input  logic ddr_rd_data_valid,
  output logic [$clog2(BUF_BEATS):0] occupancy,
  output logic busy
);
  localparam int PTR_W = $clog2(BUF_BEATS);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  typedef enum logic [1:0] {IDLE, ARB, WR_BURST, RD_BURST} state_t;
  state_t state, state_nx;
  logic last_wr;
  logic [CNT_W-1:0] beat_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [15:0] outstanding;
  logic wr_elig, rd_elig, grant_wr, grant_rd, wr_beat, rd_beat, burst_end;
  always_comb begin
    wr_elig = 32'(wr_fifo_count) >= BURST_LEN && BUF_BEATS - 32'(occupancy) >= BURST_LEN;
    rd_elig = 32'(occupancy) >= BURST_LEN && 32'(rd_space) >= BURST_LEN + 32'(outstanding);
    // on a tie the side not served last wins; last_wr resets to READ so a tie first goes to WRITE
    grant_wr = state == ARB && wr_elig && (!rd_elig || !last_wr);
    grant_rd = state == ARB && rd_elig && !grant_wr;
    wr_beat = state == WR_BURST && ddr_wr_ready;
    rd_beat = state == RD_BURST && ddr_rd_ready;
    burst_end = (wr_beat || rd_beat) && beat_cnt == CNT_W'(BURST_LEN - 1);
    state_nx = state == IDLE ? (init_calib_complete ? ARB : IDLE) :
               grant_wr ? WR_BURST : grant_rd ? RD_BURST : burst_end ? ARB : state;
    ddr_wr_valid = state == WR_BURST;
    ddr_rd_valid = state == RD_BURST;
    busy = ddr_wr_valid || ddr_rd_valid;
    wr_fifo_rd_en = wr_beat;
    ddr_wr_data = ddr_wr_valid ? wr_fifo_dout : '0;
    ddr_wr_addr = BASE_ADDR + ADDR_W'(wr_ptr) * ADDR_W'(ADDR_STEP);
    ddr_rd_addr = BASE_ADDR + ADDR_W'(rd_ptr) * ADDR_W'(ADDR_STEP);
  end
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst)
    if (ui_clk_sync_rst) begin
      state <= IDLE;
      last_wr <= 1'b0;
      beat_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occupancy <= '0;
      outstanding <= '0;
    end else begin
      state <= state_nx;
      if (grant_wr || grant_rd) begin
        last_wr <= grant_wr;
        beat_cnt <= '0;
      end else if (wr_beat || rd_beat)
        beat_cnt <= beat_cnt + 1'b1;
      if (wr_beat) wr_ptr <= wr_ptr + 1'b1;
      if (rd_beat) rd_ptr <= rd_ptr + 1'b1;
      if (burst_end) occupancy <= wr_beat ? occupancy + OCC_W'(BURST_LEN) : occupancy - OCC_W'(BURST_LEN);
      // stray returned beats with nothing outstanding are dropped rather than underflowing
      outstanding <= outstanding + 16'(rd_beat) - 16'(ddr_rd_data_valid && outstanding != '0);
    end
endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb_ddr3_rw_arbiter: directed bench for ddr3_rw_arbiter on a 128-beat ring with 32-beat bursts
module tb_ddr3_rw_arbiter;
  localparam int AW = 29;
  localparam int BL = 32;
  localparam int BUF = 128;
  logic clk = 0, rst = 1, calib = 0;
  logic [15:0] wr_fifo_count = 0, rd_space = 0;
  logic [511:0] dout, wd;
  logic rd_en, wv, rv, busy;
  logic wr_ready = 0, rd_ready = 0, dv = 0;
  logic [AW-1:0] wa, ra;
  logic [7:0] occ;
  int errors = 0, checks = 0, fifo_head = 0, wr_ptr = 0, rd_ptr = 0, occ_m = 0;

  ddr3_rw_arbiter #(.ADDR_W(AW), .BURST_LEN(BL), .ADDR_STEP(8), .BASE_ADDR('0), .BUF_BEATS(BUF)) dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib),
    .wr_fifo_count(wr_fifo_count), .wr_fifo_dout(dout), .wr_fifo_rd_en(rd_en),
    .rd_space(rd_space), .ddr_wr_valid(wv), .ddr_wr_addr(wa), .ddr_wr_data(wd),
    .ddr_wr_ready(wr_ready), .ddr_rd_valid(rv), .ddr_rd_addr(ra), .ddr_rd_ready(rd_ready),
    .ddr_rd_data_valid(dv), .occupancy(occ), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input int h);
    return {16{32'(h) ^ 32'hA5A5_0000}};
  endfunction

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input bit is_wr);
    int n = 0;
    while (!(wv || rv) && n < 20) begin
      step;
      n++;
    end
    chk(is_wr ? "grant_wr" : "grant_rd", {wv, rv}, is_wr ? 2'b10 : 2'b01);
  endtask

  task automatic wr_burst(input bit rnd);
    int beats = 0, pops = 0, n = 0;
    while (beats < BL && n < 2000) begin
      wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dout = pat(fifo_head);
      #1;
      chk("wr_valid", wv, 1);
      chk("wr_addr", wa, 64'(((wr_ptr + beats) % BUF) * 8));
      checks++;
      assert (wd === dout) else begin
        errors++;
        $error("FAIL wr_data: observed=%0h expected=%0h", wd[31:0], dout[31:0]);
      end
      chk("wr_rd_en", rd_en, wr_ready);
      if (rd_en) pops++;
      if (wr_ready) begin
        beats++;
        fifo_head++;
      end
      step;
      n++;
    end
    wr_ready = 0;
    wr_ptr = (wr_ptr + BL) % BUF;
    occ_m += BL;
    #1;
    chk("wr_end_busy", busy, 0);
    chk("wr_pops", pops, BL);
    chk("wr_occ", occ, occ_m);
  endtask

  task automatic rd_burst(input bit rnd);
    int beats = 0, n = 0;
    while (beats < BL && n < 2000) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("rd_valid", rv, 1);
      chk("rd_addr", ra, 64'(((rd_ptr + beats) % BUF) * 8));
      chk("rd_no_pop", rd_en, 0);
      if (rd_ready) beats++;
      step;
      n++;
    end
    rd_ready = 0;
    rd_ptr = (rd_ptr + BL) % BUF;
    occ_m -= BL;
    #1;
    chk("rd_end_busy", busy, 0);
    chk("rd_occ", occ, occ_m);
  endtask

  task automatic ret(input int n);
    for (int i = 0; i < n; i++) begin
      dv = 1;
      step;
    end
    dv = 0;
  endtask

  initial begin
    dout = pat(7);
    wr_fifo_count = 64;
    repeat (3) step;
    chk("rst_valid", {wv, rv, busy, rd_en}, 0);
    chk("rst_occ", occ, 0);
    chk("rst_addr", {wa, ra}, 0);
    chk("rst_data", wd[63:0], 0);
    rst = 0;
    for (int i = 0; i < 50; i++) begin
      step;
      chk("idle_no_valid", {wv, rv, busy}, 0);
    end
    calib = 1;
    step;
    chk("arb_cycle", wv, 0);
    step;
    chk("t1_grant_wr", {wv, busy}, 2'b11);
    wr_fifo_count = 32;
    wr_burst(0);
    wr_fifo_count = 0;
    repeat (3) begin
      step;
      chk("none_eligible", {wv, rv}, 0);
    end
    wr_fifo_count = 32;
    wait_grant(1);
    wr_burst(0);
    wr_fifo_count = 64;
    rd_space = 512;
    wait_grant(0);
    rd_burst(0);
    wait_grant(1);
    wr_burst(0);
    wait_grant(0);
    rd_burst(0);
    wr_fifo_count = 0;
    rd_space = 0;
    ret(64);
    ret(3);
    wr_fifo_count = 32;
    wait_grant(1);
    wr_burst(0);
    wait_grant(1);
    wr_burst(0);
    wait_grant(1);
    wr_burst(0);
    repeat (10) begin
      step;
      chk("full_blocks_wr", {wv, rv}, 0);
    end
    chk("full_occ", occ, BUF);
    rd_space = 32;
    wait_grant(0);
    rd_burst(0);
    rd_space = 0;
    wait_grant(1);
    wr_burst(0);
    wr_fifo_count = 0;
    ret(32);
    rd_space = 32;
    wait_grant(0);
    rd_burst(1);
    rd_space = 0;
    ret(32);
    wr_fifo_count = 32;
    wait_grant(1);
    wr_burst(1);
    wr_fifo_count = 0;
    rd_space = 40;
    wait_grant(0);
    rd_burst(0);
    for (int i = 0; i < 24; i++) begin
      dv = 1;
      #1;
      chk("t6_rd_held", rv, 0);
      step;
    end
    dv = 0;
    #1;
    chk("t6_rd_held_last", rv, 0);
    step;
    chk("t6_rd_granted", rv, 1);
    rd_burst(0);
    rd_space = 0;
    ret(64);
    chk("final_occ", occ, 64);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
